// File: rtl/adc_serial_reader_pkg.sv
// Shared definitions for the ADC serial reader: FSM state encoding,
// default timing constants and a counter-width helper.
package adc045_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_READ    = 2'd2,
        ST_DONE    = 2'd3
    } adc_state_e;

    localparam int DEF_FREQ_MHZ  = 50;
    localparam int DEF_CONV_US   = 1;
    localparam int DEF_DATA_BITS = 12;
    localparam int DEF_SCLK_DIV  = 2;

    // Width able to hold 0..max_val-1, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/adc_serial_reader_if.sv
// Host and ADC-side signals of the serial reader; slave is the reader's view,
// master is the view of whatever drives requests and the ADC data line.
interface adc_serial_reader_if #(
    parameter int DATA_BITS = adc045_pkg::DEF_DATA_BITS
) ();

    logic                 start;
    logic                 abort;
    logic                 adc_sdo;
    logic                 adc_cnv;
    logic                 adc_sclk;
    logic [DATA_BITS-1:0] sample;
    logic                 sample_valid;
    logic                 busy;
    logic                 overrun;

    modport master (
        output start, abort, adc_sdo,
        input  adc_cnv, adc_sclk, sample, sample_valid, busy, overrun
    );

    modport slave (
        input  start, abort, adc_sdo,
        output adc_cnv, adc_sclk, sample, sample_valid, busy, overrun
    );

endinterface

// File: rtl/adc_serial_reader_sclk_gen.sv
// Serial clock generator: adc_sclk low/high for SCLK_DIV cycles each while enabled,
// plus a strobe on the clk edge that drives adc_sclk from 0 to 1.
module sclk_gen
    import adc045_pkg::*;
#(
    parameter int SCLK_DIV = DEF_SCLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst_l,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise
);

    localparam int               DIV_W    = cnt_width(SCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_sclk;
    logic             w_phase_end;

    assign w_phase_end = i_en && (r_div_cnt == DIV_LAST);
    assign o_rise      = w_phase_end && !r_sclk;
    assign o_sclk      = r_sclk;

    // Half-period divider; dropping the enable parks sclk low immediately.
    always_ff @(posedge i_clk) begin
        if (!i_rst_l) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else if (!i_en) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else if (w_phase_end) begin
            r_div_cnt <= '0;
            r_sclk    <= ~r_sclk;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
            r_sclk    <= r_sclk;
        end
    end

endmodule

// File: rtl/adc_serial_reader.sv
// Conversion + serial readout controller for an SPI-style ADC: pulses adc_cnv,
// clocks DATA_BITS bits out MSB first and presents the completed sample.
module adc_serial_reader
    import adc045_pkg::*;
#(
    parameter int FREQ_MHZ  = DEF_FREQ_MHZ,
    parameter int CONV_US   = DEF_CONV_US,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int SCLK_DIV  = DEF_SCLK_DIV
) (
    input  logic                clk,
    input  logic                rst_l,
    adc_serial_reader_if.slave  bus
);

    localparam int CONV_CYCLES = FREQ_MHZ * CONV_US;
    localparam int READ_CYCLES = 2 * SCLK_DIV * DATA_BITS;
    localparam int CNT_MAX     = (CONV_CYCLES > READ_CYCLES) ? CONV_CYCLES : READ_CYCLES;
    localparam int CNT_W       = cnt_width(CNT_MAX);
    localparam int BIT_W       = cnt_width(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_FULL  = BIT_W'(DATA_BITS);

    adc_state_e           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_sample;
    logic                 r_cnv;
    logic                 r_sample_valid;
    logic                 r_busy;
    logic                 r_overrun;

    logic w_sclk_en;
    logic w_sclk;
    logic w_rise;

    // Gate with abort so sclk is already low on the cycle the FSM returns to IDLE.
    assign w_sclk_en = (r_state == ST_READ) && !bus.abort;

    sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .i_clk   (clk),
        .i_rst_l (rst_l),
        .i_en    (w_sclk_en),
        .o_sclk  (w_sclk),
        .o_rise  (w_rise)
    );

    // Transaction FSM with all host-visible outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_sample       <= '0;
            r_cnv          <= 1'b0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_overrun      <= bus.start && r_busy;
            r_sample_valid <= 1'b0;
            if (bus.abort) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_bit_cnt <= '0;
                r_cnv     <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            r_state   <= ST_CONVERT;
                            r_cnt     <= '0;
                            r_bit_cnt <= '0;
                            r_shift   <= '0;
                            r_cnv     <= 1'b1;
                            r_busy    <= 1'b1;
                        end else begin
                            r_cnv     <= 1'b0;
                            r_busy    <= 1'b0;
                        end
                    end
                    ST_CONVERT: begin
                        if (r_cnt == CONV_LAST) begin
                            r_state <= ST_READ;
                            r_cnt   <= '0;
                            r_cnv   <= 1'b0;
                        end else begin
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_READ: begin
                        // The last capture lands well before the final sclk period ends.
                        if (w_rise && (r_bit_cnt < BIT_FULL)) begin
                            r_shift   <= {r_shift[DATA_BITS-2:0], bus.adc_sdo};
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end else begin
                            r_shift   <= r_shift;
                        end
                        if (r_cnt == READ_LAST) begin
                            r_state        <= ST_DONE;
                            r_cnt          <= '0;
                            r_sample       <= r_shift;
                            r_sample_valid <= 1'b1;
                        end else begin
                            r_cnt          <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_cnv   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.adc_cnv      = r_cnv;
    assign bus.adc_sclk     = w_sclk;
    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_sample_valid;
    assign bus.busy         = r_busy;
    assign bus.overrun      = r_overrun;

endmodule

// File: doc/adc_serial_reader.md
ADC_SERIAL_READER -- requirements
Module: adc_serial_reader

Interface
REQ-001 Parameter FREQ_MHZ, default 50, SHALL be the clk frequency in MHz.
REQ-002 Parameter CONV_US, default 1, SHALL be the ADC conversion time in us; CONV_CYCLES = FREQ_MHZ*CONV_US.
REQ-003 Parameter DATA_BITS, default 12, SHALL be the sample width shifted out MSB first.
REQ-004 Parameter SCLK_DIV, default 2, SHALL be the adc_sclk half-period in clk cycles (>=1).
REQ-005 clk  in  1  SHALL be the single clock; all logic on its rising edge.
REQ-006 rst_l  in  1  SHALL be a synchronous, active-low reset.
REQ-007 start  in  1  SHALL request one conversion+readout when sampled high in IDLE.
REQ-008 abort  in  1  SHALL cancel any in-progress transaction.
REQ-009 adc_sdo  in  1  SHALL be the serial data from the ADC.
REQ-010 adc_cnv  out  1  SHALL be the registered ADC convert strobe.
REQ-011 adc_sclk  out  1  SHALL be the registered ADC serial clock, idle low.
REQ-012 sample  out  DATA_BITS  SHALL hold the last completed sample.
REQ-013 sample_valid  out  1  SHALL pulse one cycle when sample updates.
REQ-014 busy  out  1  SHALL be high in every state except IDLE.
REQ-015 overrun  out  1  SHALL pulse one cycle when start is high while busy.

Function
REQ-016 FSM states SHALL be IDLE, CONVERT, READ, DONE.
REQ-017 IDLE->CONVERT SHALL occur on the edge sampling start=1 and abort=0.
REQ-018 In CONVERT, adc_cnv SHALL be 1 for exactly CONV_CYCLES cycles, then READ.
REQ-019 In READ, adc_cnv SHALL be 0 and adc_sclk SHALL toggle every SCLK_DIV cycles, starting low, for DATA_BITS full periods (2*SCLK_DIV*DATA_BITS cycles).
REQ-020 adc_sdo SHALL be captured into a shift register on the clk edge that drives adc_sclk 0->1, MSB first.
REQ-021 READ->DONE SHALL occur after the last sclk period; adc_sclk SHALL be 0 in DONE.
REQ-022 In DONE (one cycle), sample SHALL equal the shifted word and sample_valid SHALL be 1; next state IDLE.
REQ-023 Latency, start-sampling edge to sample_valid high, SHALL be CONV_CYCLES + 2*SCLK_DIV*DATA_BITS + 1 cycles.
REQ-024 start while busy (including DONE) SHALL be ignored and SHALL pulse overrun next cycle.
REQ-025 abort=1 in any state SHALL force IDLE next cycle with adc_cnv=0, adc_sclk=0, no sample_valid, sample unchanged; abort has priority over start.
REQ-026 Bit and cycle counters SHALL be sized by $clog2 of their max and SHALL not wrap within a transaction.

Reset
REQ-027 rst_l=0 at a clk edge SHALL set state IDLE, adc_cnv=0, adc_sclk=0, sample=0, sample_valid=0, busy=0, overrun=0, counters=0.
REQ-028 Reset mid-transaction SHALL discard partial data; no sample_valid after release until a new start.

Structure
REQ-029 FSM state enum and default parameter constants SHALL live in shared package adc045_pkg.
REQ-030 adc_sclk generation and the rising-edge capture strobe SHALL be one sub-module, sclk_gen, enabled only in READ.

Verification (FREQ_MHZ=50, CONV_US=1, DATA_BITS=12, SCLK_DIV=2; latency 99)
REQ-031 start pulse at cycle 0, ADC model drives 12'hA5C -> adc_cnv high cycles 1-50, 12 sclk periods, sample_valid at cycle 99 with sample=12'hA5C.
REQ-032 start held high continuously -> back-to-back conversions, overrun pulses each busy cycle, every sample correct.
REQ-033 abort at cycle 70 (mid READ) -> IDLE at 71, sclk/cnv low, no sample_valid, sample keeps prior value.
REQ-034 rst_l low at cycle 30 (CONVERT) -> all outputs reset next edge; a new start yields valid sample 99 cycles later.
REQ-035 start and abort high same cycle in IDLE -> remains IDLE, busy=0, no overrun.
REQ-036 adc_sdo all ones then all zeros -> sample=12'hFFF then 12'h000.
